// File: rtl/l2_ddr_scheduler_if.sv
// DDR request/data handshake between the L2 DDR scheduler (master) and the DDR controller (slave).
interface l2_ddr_scheduler_if;
  logic        ddr_req;
  logic        ddr_req_wr;
  logic [27:0] ddr_addr;
  logic        ddr_ack;
  logic        ddr_rd_valid;
  logic        ddr_rd_ready;
  logic        ddr_wr_ready;

  modport master (
    output ddr_req, ddr_req_wr, ddr_addr, ddr_rd_ready,
    input  ddr_ack, ddr_rd_valid, ddr_wr_ready
  );

  modport slave (
    input  ddr_req, ddr_req_wr, ddr_addr, ddr_rd_ready,
    output ddr_ack, ddr_rd_valid, ddr_wr_ready
  );
endinterface

// File: rtl/l2_ddr_scheduler.sv
// Schedules L2 prefetch fills from DDR and flush drains back to DDR, one burst at a time,
// and tracks the L2 window base address. BURST_BEATS must be a power of two.
module l2_ddr_scheduler #(
  parameter logic [11:0] LOW_WATER   = 12'd512,
  parameter int          BURST_BEATS = 8
) (
  input  logic               clk_166M66,
  input  logic               mcu_sys_rst_n,
  input  logic               i_cfg_load,
  input  logic [27:0]        i_cfg_base_addr,
  input  logic               i_fill_enable,
  input  logic               i_flush_req,
  input  logic [8:0]         i_flush_lines,
  input  logic [11:0]        i_l2_unread_size,
  input  logic               i_l1ddr_rw_conflicts,
  input  logic               i_ddr_base_addr_inc,
  input  logic               i_ddr_base_addr_dec,
  output logic               o_ddr_operate_enable,
  output logic               o_ddr_rw,
  l2_ddr_scheduler_if.master ddr,
  output logic [27:0]        o_window_base,
  output logic               o_busy,
  output logic               o_flush_done
);

  localparam int                BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
  localparam logic [27:0]       BURST_BYTES = 28'(BURST_BEATS * 16);

  typedef enum logic [2:0] {
    IDLE,
    REQ_RD,
    FILL,
    REQ_WR,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [27:0]       fill_ptr;
  logic [27:0]       drain_ptr;
  logic              flush_pending;
  logic [8:0]        flush_remaining;
  logic              fill_beat;
  logic              drain_beat;
  logic              last_beat;
  logic              cfg_take;
  logic              flush_take;

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign cfg_take   = i_cfg_load && (state == IDLE) && !flush_pending;
  // A pending flush (queued or draining) shadows any further flush pulse.
  assign flush_take = i_flush_req && !flush_pending;
  assign o_busy     = (state != IDLE) || flush_pending;

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    ddr.ddr_req          = 1'b0;
    ddr.ddr_req_wr       = 1'b0;
    ddr.ddr_addr         = '0;
    ddr.ddr_rd_ready     = 1'b0;
    o_ddr_operate_enable = 1'b0;
    o_ddr_rw             = 1'b0;
    fill_beat            = 1'b0;
    drain_beat           = 1'b0;
    case (state)
      IDLE: begin
        if (flush_pending && !i_l1ddr_rw_conflicts) begin
          state_nxt = REQ_WR;
        end else if (i_fill_enable && (i_l2_unread_size < LOW_WATER) && !i_l1ddr_rw_conflicts) begin
          state_nxt = REQ_RD;
        end
      end
      REQ_RD: begin
        ddr.ddr_req  = 1'b1;
        ddr.ddr_addr = fill_ptr;
        if (ddr.ddr_ack) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        // Conflicts only hold off beats; the burst itself always completes.
        ddr.ddr_rd_ready     = !i_l1ddr_rw_conflicts;
        fill_beat            = ddr.ddr_rd_valid && !i_l1ddr_rw_conflicts;
        o_ddr_operate_enable = fill_beat;
        o_ddr_rw             = fill_beat;
        if (fill_beat && last_beat) begin
          state_nxt = IDLE;
        end
      end
      REQ_WR: begin
        ddr.ddr_req    = 1'b1;
        ddr.ddr_req_wr = 1'b1;
        ddr.ddr_addr   = drain_ptr;
        if (ddr.ddr_ack) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        drain_beat           = ddr.ddr_wr_ready && !i_l1ddr_rw_conflicts;
        o_ddr_operate_enable = drain_beat;
        if (drain_beat && last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      beat_cnt <= '0;
    end else if (fill_beat || drain_beat) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      fill_ptr  <= '0;
      drain_ptr <= '0;
    end else if (cfg_take) begin
      fill_ptr  <= i_cfg_base_addr;
      drain_ptr <= i_cfg_base_addr;
    end else begin
      if (fill_beat && last_beat) begin
        fill_ptr <= fill_ptr + BURST_BYTES;
      end
      if (drain_beat && last_beat) begin
        drain_ptr <= drain_ptr + BURST_BYTES;
      end
    end
  end

  // Window tracking runs in every state; a simultaneous inc and dec cancel out.
  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      o_window_base <= '0;
    end else if (cfg_take) begin
      o_window_base <= i_cfg_base_addr;
    end else if (i_ddr_base_addr_inc && !i_ddr_base_addr_dec) begin
      o_window_base <= o_window_base + 28'd16;
    end else if (i_ddr_base_addr_dec && !i_ddr_base_addr_inc) begin
      o_window_base <= o_window_base - 28'd16;
    end
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      flush_pending   <= 1'b0;
      flush_remaining <= '0;
      o_flush_done    <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      if (flush_take) begin
        if (i_flush_lines == 9'd0) begin
          o_flush_done <= 1'b1;
        end else begin
          flush_pending   <= 1'b1;
          flush_remaining <= i_flush_lines;
        end
      end else if (drain_beat && last_beat) begin
        flush_remaining <= flush_remaining - 9'd1;
        if (flush_remaining == 9'd1) begin
          flush_pending <= 1'b0;
          o_flush_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_ddr_scheduler.sv
// Randomized scoreboard bench for l2_ddr_scheduler: expected DDR requests, beat strobes and
// flush completions are queued from an address-level model and popped by a separate monitor.
module tb_l2_ddr_scheduler;

  localparam int          BB          = 8;
  localparam logic [11:0] LW          = 12'd512;
  localparam logic [27:0] BURST_BYTES = 28'(BB * 16);

  logic        clk_166M66 = 1'b0;
  logic        mcu_sys_rst_n;
  logic        i_cfg_load;
  logic [27:0] i_cfg_base_addr;
  logic        i_fill_enable;
  logic        i_flush_req;
  logic [8:0]  i_flush_lines;
  logic [11:0] i_l2_unread_size;
  logic        i_l1ddr_rw_conflicts;
  logic        i_ddr_base_addr_inc;
  logic        i_ddr_base_addr_dec;
  logic        o_ddr_operate_enable;
  logic        o_ddr_rw;
  logic [27:0] o_window_base;
  logic        o_busy;
  logic        o_flush_done;

  l2_ddr_scheduler_if ddr_if ();

  l2_ddr_scheduler #(.LOW_WATER(LW), .BURST_BEATS(BB)) dut (
    .clk_166M66           (clk_166M66),
    .mcu_sys_rst_n        (mcu_sys_rst_n),
    .i_cfg_load           (i_cfg_load),
    .i_cfg_base_addr      (i_cfg_base_addr),
    .i_fill_enable        (i_fill_enable),
    .i_flush_req          (i_flush_req),
    .i_flush_lines        (i_flush_lines),
    .i_l2_unread_size     (i_l2_unread_size),
    .i_l1ddr_rw_conflicts (i_l1ddr_rw_conflicts),
    .i_ddr_base_addr_inc  (i_ddr_base_addr_inc),
    .i_ddr_base_addr_dec  (i_ddr_base_addr_dec),
    .o_ddr_operate_enable (o_ddr_operate_enable),
    .o_ddr_rw             (o_ddr_rw),
    .ddr                  (ddr_if),
    .o_window_base        (o_window_base),
    .o_busy               (o_busy),
    .o_flush_done         (o_flush_done)
  );

  always #3 clk_166M66 = ~clk_166M66;

  typedef struct packed {
    logic        wr;
    logic [27:0] addr;
  } req_t;

  req_t        req_q[$];
  bit          beat_q[$];
  int          done_q[$];
  logic [27:0] fill_m;
  logic [27:0] drain_m;
  logic [27:0] win_m;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_166M66);
    #1;
  endtask

  // Monitor: every DUT-presented event is matched against the head of its queue.
  always @(negedge clk_166M66) begin
    if (mcu_sys_rst_n) begin
      if (ddr_if.ddr_req) begin
        checkOutput("ddr_req expected", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          checkOutput("ddr_req_wr", 32'(ddr_if.ddr_req_wr), 32'(req_q[0].wr));
          checkOutput("ddr_addr", 32'(ddr_if.ddr_addr), 32'(req_q[0].addr));
          if (ddr_if.ddr_ack) void'(req_q.pop_front());
        end
      end
      if (o_ddr_operate_enable) begin
        checkOutput("strobe expected", 32'(beat_q.size() != 0), 32'd1);
        if (beat_q.size() != 0) checkOutput("o_ddr_rw", 32'(o_ddr_rw), 32'(beat_q.pop_front()));
      end
      if (o_flush_done) begin
        checkOutput("flush_done expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) void'(done_q.pop_front());
      end
    end
  end

  task automatic expectFill();
    req_q.push_back(req_t'({1'b0, fill_m}));
    repeat (BB) beat_q.push_back(1'b1);
    fill_m = fill_m + BURST_BYTES;
  endtask

  task automatic expectFlush(input int lines);
    for (int k = 0; k < lines; k++) begin
      req_q.push_back(req_t'({1'b1, drain_m}));
      repeat (BB) beat_q.push_back(1'b0);
      drain_m = drain_m + BURST_BYTES;
    end
    done_q.push_back(1);
  endtask

  task automatic startFill(input logic [11:0] unread);
    i_l2_unread_size = unread;
    i_fill_enable    = 1'b1;
    tick();
    i_fill_enable    = 1'b0;
    i_l2_unread_size = LW;
  endtask

  task automatic serviceBurst(input bit wr, input int ack_delay, input logic [31:0] vmask,
                              input logic [31:0] cmask, input int flush_at,
                              input logic [8:0] flush_n, input bit fill_after);
    int n;
    int beats;
    bit v;
    bit c;
    n = 0;
    @(negedge clk_166M66);
    while (!ddr_if.ddr_req && n < 20) begin
      tick();
      n++;
      @(negedge clk_166M66);
    end
    checkOutput("ddr_req raised", 32'(ddr_if.ddr_req), 32'd1);
    if (!ddr_if.ddr_req) return;
    checkOutput("o_busy during request", 32'(o_busy), 32'd1);
    i_fill_enable = fill_after;
    repeat (ack_delay) tick();
    ddr_if.ddr_ack = 1'b1;
    tick();
    ddr_if.ddr_ack = 1'b0;
    beats = 0;
    for (int i = 0; i < 64 && beats < BB; i++) begin
      v = (i < 32) ? vmask[i] : 1'b1;
      c = (i < 32) ? cmask[i] : 1'b0;
      if (wr) ddr_if.ddr_wr_ready = v;
      else    ddr_if.ddr_rd_valid = v;
      i_l1ddr_rw_conflicts = c;
      i_flush_req          = (i == flush_at);
      i_flush_lines        = flush_n;
      @(negedge clk_166M66);
      checkOutput("o_ddr_rd_ready", 32'(ddr_if.ddr_rd_ready), 32'(!wr && !c));
      checkOutput("o_ddr_operate_enable", 32'(o_ddr_operate_enable), 32'(v && !c));
      if (v && !c) beats++;
      tick();
    end
    ddr_if.ddr_wr_ready  = 1'b0;
    ddr_if.ddr_rd_valid  = 1'b0;
    i_l1ddr_rw_conflicts = 1'b0;
    i_flush_req          = 1'b0;
  endtask

  task automatic checkFlushDone();
    @(negedge clk_166M66);
    checkOutput("o_flush_done pulse", 32'(o_flush_done), 32'd1);
    checkOutput("o_busy after flush", 32'(o_busy), 32'd0);
    tick();
    @(negedge clk_166M66);
    checkOutput("o_flush_done one cycle", 32'(o_flush_done), 32'd0);
  endtask

  task automatic runFlush(input int lines, input bit prio, input int ack_delay, input int ign_at);
    expectFlush(lines);
    i_flush_lines    = 9'(lines);
    i_flush_req      = 1'b1;
    tick();
    i_flush_req      = 1'b0;
    i_fill_enable    = prio;
    i_l2_unread_size = prio ? 12'd100 : LW;
    for (int k = 0; k < lines; k++)
      serviceBurst(1'b1, ack_delay, $urandom, $urandom & $urandom, ign_at, 9'd5, prio && (k < lines - 1));
    i_fill_enable    = 1'b0;
    i_l2_unread_size = LW;
    if (lines > 0) checkFlushDone();
  endtask

  task automatic applyStimulus(input logic inc, input logic dec);
    i_ddr_base_addr_inc = inc;
    i_ddr_base_addr_dec = dec;
    tick();
    i_ddr_base_addr_inc = 1'b0;
    i_ddr_base_addr_dec = 1'b0;
    if (inc && !dec) win_m = win_m + 28'd16;
    else if (dec && !inc) win_m = win_m - 28'd16;
    @(negedge clk_166M66);
    checkOutput("o_window_base", 32'(o_window_base), 32'(win_m));
  endtask

  task automatic cfgLoad(input logic [27:0] base, input logic inc, input logic dec);
    i_cfg_base_addr     = base;
    i_cfg_load          = 1'b1;
    i_ddr_base_addr_inc = inc;
    i_ddr_base_addr_dec = dec;
    tick();
    i_cfg_load          = 1'b0;
    i_ddr_base_addr_inc = 1'b0;
    i_ddr_base_addr_dec = 1'b0;
    fill_m  = base;
    drain_m = base;
    win_m   = base;
    @(negedge clk_166M66);
    checkOutput("o_window_base after cfg", 32'(o_window_base), 32'(win_m));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mcu_sys_rst_n        = 1'b0;
    i_cfg_load           = 1'b0;
    i_cfg_base_addr      = '0;
    i_fill_enable        = 1'b0;
    i_flush_req          = 1'b0;
    i_flush_lines        = '0;
    i_l2_unread_size     = LW;
    i_l1ddr_rw_conflicts = 1'b0;
    i_ddr_base_addr_inc  = 1'b0;
    i_ddr_base_addr_dec  = 1'b0;
    ddr_if.ddr_ack       = 1'b0;
    ddr_if.ddr_rd_valid  = 1'b0;
    ddr_if.ddr_wr_ready  = 1'b0;
    fill_m  = '0;
    drain_m = '0;
    win_m   = '0;
    repeat (3) tick();
    checkOutput("reset o_busy", 32'(o_busy), 32'd0);
    checkOutput("reset ddr_req", 32'(ddr_if.ddr_req), 32'd0);
    checkOutput("reset o_window_base", 32'(o_window_base), 32'd0);
    checkOutput("reset o_flush_done", 32'(o_flush_done), 32'd0);
    checkOutput("reset o_ddr_operate_enable", 32'(o_ddr_operate_enable), 32'd0);
    mcu_sys_rst_n = 1'b1;
    tick();

    $display("[TB] basic fill from 0x100");
    cfgLoad(28'h100, 1'b1, 1'b0);
    expectFill();
    startFill(12'd100);
    serviceBurst(1'b0, 3, 32'hFFFF_FFFF, 32'h0, -1, 9'd0, 1'b0);
    @(negedge clk_166M66);
    checkOutput("o_busy after fill", 32'(o_busy), 32'd0);

    $display("[TB] fill with 3-cycle conflict");
    expectFill();
    startFill(12'd0);
    serviceBurst(1'b0, 0, 32'hFFFF_FFFF, 32'h0000_001C, -1, 9'd0, 1'b0);

    $display("[TB] flush of 2 lines with fill eligible");
    runFlush(2, 1'b1, 1, -1);

    $display("[TB] zero-line flush");
    runFlush(0, 1'b0, 0, -1);
    checkFlushDone();

    $display("[TB] cfg_load ignored while flush pending");
    expectFlush(1);
    i_l1ddr_rw_conflicts = 1'b1;
    i_flush_lines        = 9'd1;
    i_flush_req          = 1'b1;
    tick();
    i_flush_req = 1'b0;
    @(negedge clk_166M66);
    checkOutput("o_busy with pending flush", 32'(o_busy), 32'd1);
    checkOutput("ddr_req held off by conflict", 32'(ddr_if.ddr_req), 32'd0);
    i_cfg_base_addr = 28'h555_0000;
    i_cfg_load      = 1'b1;
    tick();
    i_cfg_load = 1'b0;
    @(negedge clk_166M66);
    checkOutput("o_window_base kept", 32'(o_window_base), 32'(win_m));
    i_l1ddr_rw_conflicts = 1'b0;
    serviceBurst(1'b1, 2, $urandom, 32'h0, -1, 9'd0, 1'b0);
    checkFlushDone();

    $display("[TB] flush latched during fill, pulse ignored during drain");
    expectFill();
    expectFlush(1);
    startFill(12'd7);
    serviceBurst(1'b0, 1, 32'hFFFF_FFFF, 32'h0, 2, 9'd1, 1'b0);
    serviceBurst(1'b1, 0, 32'hFFFF_FFFF, 32'h0, 3, 9'd5, 1'b0);
    checkFlushDone();

    $display("[TB] reset at fill beat 4");
    expectFill();
    startFill(12'd50);
    @(negedge clk_166M66);
    checkOutput("ddr_req before reset", 32'(ddr_if.ddr_req), 32'd1);
    ddr_if.ddr_ack = 1'b1;
    tick();
    ddr_if.ddr_ack      = 1'b0;
    ddr_if.ddr_rd_valid = 1'b1;
    repeat (4) tick();
    mcu_sys_rst_n = 1'b0;
    #1;
    checkOutput("rst ddr_req", 32'(ddr_if.ddr_req), 32'd0);
    checkOutput("rst ddr_req_wr", 32'(ddr_if.ddr_req_wr), 32'd0);
    checkOutput("rst ddr_addr", 32'(ddr_if.ddr_addr), 32'd0);
    checkOutput("rst ddr_rd_ready", 32'(ddr_if.ddr_rd_ready), 32'd0);
    checkOutput("rst o_ddr_operate_enable", 32'(o_ddr_operate_enable), 32'd0);
    checkOutput("rst o_ddr_rw", 32'(o_ddr_rw), 32'd0);
    checkOutput("rst o_window_base", 32'(o_window_base), 32'd0);
    checkOutput("rst o_busy", 32'(o_busy), 32'd0);
    checkOutput("rst o_flush_done", 32'(o_flush_done), 32'd0);
    ddr_if.ddr_rd_valid = 1'b0;
    req_q.delete();
    beat_q.delete();
    fill_m  = '0;
    drain_m = '0;
    win_m   = '0;
    repeat (2) tick();
    mcu_sys_rst_n    = 1'b1;
    i_l2_unread_size = LW;
    i_fill_enable    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_166M66);
      checkOutput("idle after reset o_busy", 32'(o_busy), 32'd0);
      checkOutput("idle after reset ddr_req", 32'(ddr_if.ddr_req), 32'd0);
      tick();
    end
    i_fill_enable = 1'b0;

    $display("[TB] window inc/dec");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] fill pointer wrap");
    cfgLoad(28'hFFF_FF80, 1'b0, 1'b1);
    expectFill();
    startFill(12'd511);
    serviceBurst(1'b0, 0, $urandom, $urandom & $urandom, -1, 9'd0, 1'b0);
    expectFill();
    startFill(12'd1);
    serviceBurst(1'b0, 2, $urandom, $urandom & $urandom, -1, 9'd0, 1'b0);

    $display("[TB] randomized operations");
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          expectFill();
          startFill(12'($urandom_range(0, int'(LW) - 1)));
          serviceBurst(1'b0, $urandom_range(0, 3), $urandom, $urandom & $urandom, -1, 9'd0, 1'b0);
          @(negedge clk_166M66);
          checkOutput("o_busy after random fill", 32'(o_busy), 32'd0);
        end
        1: runFlush($urandom_range(1, 3), 1'($urandom), $urandom_range(0, 3),
                    ($urandom % 2) ? $urandom_range(0, 6) : -1);
        2: repeat (4) applyStimulus(1'($urandom), 1'($urandom));
        default: cfgLoad(($urandom % 2) ? 28'hFFF_FF00 : (28'($urandom) & 28'hFFF_FFF0),
                         1'($urandom), 1'($urandom));
      endcase
    end

    repeat (4) tick();
    checkOutput("leftover requests", 32'(req_q.size()), 32'd0);
    checkOutput("leftover beats", 32'(beat_q.size()), 32'd0);
    checkOutput("leftover flush_done", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_ddr_scheduler.md
L2_DDR_SCHEDULER -- requirements
Module: l2_ddr_scheduler

Interface
REQ-001 SHALL have parameter LOW_WATER, default 12'd512: fill threshold, in 16-bit words of L2 unread size.
REQ-002 SHALL have parameter BURST_BEATS, default 8: 128-bit beats per DDR burst; power of two only.
REQ-003 SHALL have port clk_166M66, input, 1 bit: clock.
REQ-004 SHALL have port mcu_sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_cfg_load, input, 1 bit: pulse that loads i_cfg_base_addr.
REQ-006 SHALL have port i_cfg_base_addr, input, 28 bits: DDR byte address.
REQ-007 SHALL have port i_fill_enable, input, 1 bit: permits prefetch fills.
REQ-008 SHALL have port i_flush_req, input, 1 bit: pulse that starts a drain of i_flush_lines bursts.
REQ-009 SHALL have port i_flush_lines, input, 9 bits: number of bursts to drain; 0 means no-op.
REQ-010 SHALL have port i_l2_unread_size, input, 12 bits: from L2 cache.
REQ-011 SHALL have port i_l1ddr_rw_conflicts, input, 1 bit: from L2 cache.
REQ-012 SHALL have ports i_ddr_base_addr_inc and i_ddr_base_addr_dec, input, 1 bit each: from L2 cache.
REQ-013 SHALL have ports o_ddr_operate_enable and o_ddr_rw, output, 1 bit each: L2 port-B strobe; rw=1 writes into L2.
REQ-014 SHALL have ports o_ddr_req (output, 1), o_ddr_req_wr (output, 1; 1 = write to DDR), o_ddr_addr (output, 28) and i_ddr_ack (input, 1).
REQ-015 SHALL have ports i_ddr_rd_valid (input, 1), o_ddr_rd_ready (output, 1) and i_ddr_wr_ready (input, 1).
REQ-016 SHALL have ports o_window_base (output, 28), o_busy (output, 1) and o_flush_done (output, 1).

Function
REQ-017 SHALL implement FSM states IDLE, REQ_RD, FILL, REQ_WR, DRAIN.
REQ-018 IDLE SHALL go to REQ_WR when a flush is pending and i_l1ddr_rw_conflicts=0; flush has priority over fill.
REQ-019 IDLE SHALL otherwise go to REQ_RD when i_fill_enable=1, i_l2_unread_size<LOW_WATER and i_l1ddr_rw_conflicts=0.
REQ-020 A flush pulse SHALL be latched in any state together with its line count; a pulse during an active drain SHALL be ignored.
REQ-021 REQ_RD/REQ_WR SHALL hold o_ddr_req=1 and a stable o_ddr_addr (fill_ptr or drain_ptr) until the i_ddr_ack cycle, then enter FILL/DRAIN; o_ddr_req_wr=1 only in REQ_WR.
REQ-022 o_ddr_rd_ready SHALL equal (state==FILL && !i_l1ddr_rw_conflicts), combinationally.
REQ-023 A fill beat occurs on i_ddr_rd_valid && o_ddr_rd_ready; o_ddr_operate_enable=1 and o_ddr_rw=1 SHALL be asserted in that same cycle.
REQ-024 A drain beat occurs on state==DRAIN && i_ddr_wr_ready && !i_l1ddr_rw_conflicts; o_ddr_operate_enable=1 and o_ddr_rw=0 SHALL be asserted in that same cycle.
REQ-025 The beat counter SHALL count 0..BURST_BEATS-1; on the last beat the matching pointer SHALL advance by BURST_BEATS*16 bytes (mod 2^28) and the FSM return to IDLE.
REQ-026 A drain burst SHALL decrement the remaining-line count; when it reaches 0, o_flush_done SHALL pulse for 1 cycle on return to IDLE.
REQ-027 A flush with i_flush_lines=0 SHALL pulse o_flush_done the cycle after latch, with no DDR request.
REQ-028 o_window_base SHALL add 16 on i_ddr_base_addr_inc and subtract 16 on i_ddr_base_addr_dec, wrapping mod 2^28; both asserted together SHALL leave it unchanged. This update SHALL apply in every state.
REQ-029 i_cfg_load SHALL load fill_ptr, drain_ptr and o_window_base only in IDLE with no pending flush; otherwise it SHALL be ignored. cfg_load SHALL win over a same-cycle inc/dec.
REQ-030 o_busy SHALL be 1 in every state except IDLE, and also while a flush is pending.
REQ-031 A conflict during FILL/DRAIN SHALL stall beats only, never abort a burst.

Reset
REQ-032 Reset SHALL force IDLE asynchronously, including mid-burst, and discard the pending flush and the beat count.
REQ-033 Reset SHALL zero the pointers, o_window_base and all 1-bit outputs.

Verification
REQ-034 Fill: cfg base 0x100, unread 100, fill_en=1, ack cycle 3, 8 valid beats -> o_ddr_addr=0x100 during req; 8 strobes with rw=1; fill_ptr=0x180; back to IDLE.
REQ-035 Flush priority: flush_lines=2 with fill also eligible -> two REQ_WR bursts at drain_ptr then +0x80; o_flush_done pulses once after the 16th beat.
REQ-036 Conflict: conflicts=1 during FILL for 3 cycles -> o_ddr_rd_ready=0 and no strobes for those 3 cycles; burst completes afterwards.
REQ-037 Window: inc and dec together -> o_window_base unchanged; dec from 0 -> 0xFFFFFF0.
REQ-038 Reset asserted at FILL beat 4 -> all outputs 0 immediately; after release with unread>=LOW_WATER, stays IDLE.
REQ-039 Flush with lines=0 -> o_flush_done pulses 1 cycle; o_ddr_req never asserted.
